// File: rtl/ultrasound_capture_writer.sv
// Packs 16-bit ADC samples four per 64-bit word and writes them to an on-chip RAM
// after a trigger. Writes the final partial word with byte enables for the filled lanes only.
module ultrasound_capture_writer #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned MAX_SAMPLES = 32768
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              trigger,
  input  logic              abort,
  input  logic [15:0]       num_samples,
  input  logic [15:0]       sample_data,
  input  logic              sample_valid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [63:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic              clamped,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [16:0] MaxS = 17'(MAX_SAMPLES);

  typedef enum logic [2:0] {StIdle, StArmed, StCapture, StFlush, StDone} state_e;
  state_e state_q, state_d;

  logic [16:0]       num_ext, n_eff, n_q, cnt_q;
  logic [1:0]        lane_q;
  logic [63:0]       acc_q, lane_word, wdata_q;
  logic [7:0]        be_q, be_fill;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   wr_addr_q, words_written_q;
  logic              wr_pend_q, clamped_q, clken_q;
  logic              last, accept;

  assign num_ext = {1'b0, num_samples};
  assign n_eff   = (num_ext > MaxS) ? MaxS : num_ext;
  assign last    = (cnt_q + 17'd1) == n_q;
  assign accept  = (state_q == StCapture) && sample_valid && !abort;

  // Lane 0 starts a fresh word so unfilled upper lanes of a partial word read as zero.
  always_comb begin
    lane_word = (lane_q == 2'd0) ? 64'd0 : acc_q;
    lane_word[{lane_q, 4'b0000} +: 16] = sample_data;
    case (lane_q)
      2'd0:    be_fill = 8'h03;
      2'd1:    be_fill = 8'h0F;
      2'd2:    be_fill = 8'h3F;
      default: be_fill = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start) state_d = (n_eff == 17'd0) ? StDone : StArmed;
      StArmed: begin
        if (abort)        state_d = StIdle;
        else if (trigger) state_d = StCapture;
      end
      StCapture: begin
        if (abort)                      state_d = StIdle;
        else if (sample_valid && last)  state_d = StFlush;
      end
      StFlush:   state_d = abort ? StIdle : StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q             <= '0;
      cnt_q           <= '0;
      lane_q          <= '0;
      acc_q           <= '0;
      wdata_q         <= '0;
      be_q            <= '0;
      addr_q          <= '0;
      wr_addr_q       <= '0;
      words_written_q <= '0;
      wr_pend_q       <= 1'b0;
      clamped_q       <= 1'b0;
      clken_q         <= 1'b0;
    end else begin
      clken_q   <= 1'b1;
      wr_pend_q <= 1'b0;
      if (mem_write) words_written_q <= words_written_q + 1'b1;
      if (state_q == StIdle && start) begin
        n_q             <= n_eff;
        clamped_q       <= num_ext > MaxS;
        cnt_q           <= '0;
        lane_q          <= '0;
        acc_q           <= '0;
        wr_addr_q       <= '0;
        words_written_q <= '0;
      end
      if (accept) begin
        cnt_q  <= cnt_q + 17'd1;
        lane_q <= lane_q + 2'd1;
        acc_q  <= lane_word;
        // Stage the completed word separately so the next sample can refill lane 0.
        if (last || lane_q == 2'd3) begin
          wr_pend_q <= 1'b1;
          wdata_q   <= lane_word;
          be_q      <= be_fill;
          addr_q    <= wr_addr_q[ADDR_W-1:0];
          wr_addr_q <= wr_addr_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy           = (state_q == StArmed) || (state_q == StCapture) || (state_q == StFlush);
    done           = state_q == StDone;
    mem_write      = wr_pend_q && !abort && ((state_q == StCapture) || (state_q == StFlush));
    mem_chipselect = mem_write;
    mem_address    = addr_q;
    mem_byteenable = be_q;
    mem_writedata  = wdata_q;
    mem_clken      = clken_q;
    clamped        = clamped_q;
    words_written  = words_written_q;
  end

endmodule

// File: tb/tb_ultrasound_capture_writer.sv
// Bench for ultrasound_capture_writer: vector table of captures plus abort/reset sequences,
// with expected RAM writes queued at stimulus time and popped when the DUT writes.
module tb_ultrasound_capture_writer;

  localparam int MaxSamples = 32768;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, trigger = 1'b0, abort = 1'b0, sample_valid = 1'b0;
  logic [15:0] num_samples = '0, sample_data = '0;
  logic [12:0] mem_address;
  logic [7:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, busy, done, clamped;
  logic [63:0] mem_writedata;
  logic [13:0] words_written;

  ultrasound_capture_writer #(.ADDR_W(13), .MAX_SAMPLES(MaxSamples)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .trigger(trigger), .abort(abort),
    .num_samples(num_samples), .sample_data(sample_data), .sample_valid(sample_valid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .busy(busy), .done(done), .clamped(clamped),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_t;

  typedef struct {
    int num;
    int base;
    bit gap;
    int exp_ww;
    bit exp_clamp;
  } vec_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  logic [12:0] last_addr = '0;
  logic [63:0] last_data = '0;
  logic [7:0]  last_be = '0;
  vec_t        vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Samples outputs at the falling edge, then returns just after the next rising edge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (mem_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=addr %0h data %h required=no write",
                 mem_address, mem_writedata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_address), 64'(e.addr));
        chk("wr_data", mem_writedata, e.data);
        chk("wr_be", 64'(mem_byteenable), 64'(e.be));
        chk("wr_cs", 64'(mem_chipselect), 64'd1);
      end
      last_addr = mem_address;
      last_data = mem_writedata;
      last_be   = mem_byteenable;
    end
    if (done) done_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int addr, input logic [63:0] word, input int lane);
    wr_t w;
    w.addr = 13'(addr);
    w.data = word;
    case (lane)
      0:       w.be = 8'h03;
      1:       w.be = 8'h0F;
      2:       w.be = 8'h3F;
      default: w.be = 8'hFF;
    endcase
    exp_q.push_back(w);
  endtask

  task automatic run_capture(input int num, input int base, input bit gap, input int exp_ww,
                             input bit exp_clamp);
    int          n;
    int          addr;
    int          lane;
    logic [63:0] word;
    n = (num > MaxSamples) ? MaxSamples : num;
    done_seen = 0;
    num_samples = 16'(num);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (n == 0) begin
      tick();
      chk("zero_done_timing", 64'(done_seen), 64'd1);
      tick();
    end else begin
      chk("busy_armed", 64'(busy), 64'd1);
      // Junk samples and a second start while armed must be ignored.
      start = 1'b1;
      num_samples = 16'd3;
      sample_valid = 1'b1;
      sample_data = 16'hDEAD;
      tick();
      tick();
      start = 1'b0;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      word = '0;
      addr = 0;
      for (int i = 0; i < n; i++) begin
        lane = i % 4;
        if (lane == 0) word = '0;
        sample_valid = 1'b1;
        sample_data = 16'(base * (i + 1));
        word[16*lane +: 16] = sample_data;
        if (lane == 3 || i == n - 1) begin
          push_word(addr, word, lane);
          addr++;
        end
        tick();
        if (gap && (i % 2 == 1)) begin
          sample_valid = 1'b0;
          tick();
        end
      end
      sample_valid = 1'b1;
      sample_data = 16'hBEEF;
      for (int t = 0; t < 8 && done_seen == 0; t++) tick();
      sample_valid = 1'b0;
      tick();
      chk("done_pulses", 64'(done_seen), 64'd1);
    end
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("words_written", 64'(words_written), 64'(exp_ww));
    chk("clamped", 64'(clamped), 64'(exp_clamp));
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    vecs[0] = '{num: 8,     base: 1,      gap: 1'b0, exp_ww: 2,    exp_clamp: 1'b0};
    vecs[1] = '{num: 5,     base: 'h1111, gap: 1'b1, exp_ww: 2,    exp_clamp: 1'b0};
    vecs[2] = '{num: 0,     base: 3,      gap: 1'b0, exp_ww: 0,    exp_clamp: 1'b0};
    vecs[3] = '{num: 7,     base: 'h0101, gap: 1'b1, exp_ww: 2,    exp_clamp: 1'b0};
    vecs[4] = '{num: 40000, base: 7,      gap: 1'b0, exp_ww: 8192, exp_clamp: 1'b1};
    vecs[5] = '{num: 4,     base: 'h2222, gap: 1'b0, exp_ww: 1,    exp_clamp: 1'b0};

    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_clken", 64'(mem_clken), 64'd0);
    chk("rst_write", 64'(mem_write), 64'd0);
    chk("rst_ww", 64'(words_written), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    chk("clken_after_reset", 64'(mem_clken), 64'd1);

    for (int k = 0; k < 6; k++) begin
      run_capture(vecs[k].num, vecs[k].base, vecs[k].gap, vecs[k].exp_ww, vecs[k].exp_clamp);
      if (k == 0) chk("v8_last_data", last_data, 64'h0008000700060005);
      if (k == 1) begin
        chk("v5_last_data", last_data, 64'h0000000000005555);
        chk("v5_last_be", 64'(last_be), 64'h03);
      end
      if (k == 4) chk("clamp_last_addr", 64'(last_addr), 64'd8191);
    end

    // Abort after 6 of 12 samples: only word 0 lands, no done.
    done_seen = 0;
    num_samples = 16'd12;
    start = 1'b1;
    tick();
    start = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample_valid = 1'b1;
      sample_data = 16'(i + 'h10);
      if (i == 3) push_word(0, 64'h0013001200110010, 3);
      tick();
    end
    sample_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ww", 64'(words_written), 64'd1);
    chk("abort_no_done", 64'(done_seen), 64'd0);
    chk("abort_queue", 64'(exp_q.size()), 64'd0);

    // Abort on the cycle a full word would be written: the write is dropped.
    num_samples = 16'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1;
      sample_data = 16'(i + 1);
      tick();
    end
    sample_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("abort_wr_ww", 64'(words_written), 64'd0);
    chk("abort_wr_busy", 64'(busy), 64'd0);

    run_capture(4, 'h3333, 1'b0, 1, 1'b0);

    // Reset in the middle of a clamped capture.
    num_samples = 16'd40000;
    start = 1'b1;
    tick();
    start = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_data = 16'(i + 'h40);
      tick();
    end
    chk("pre_reset_clamped", 64'(clamped), 64'd1);
    reset_n = 1'b0;
    #2;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_clamped", 64'(clamped), 64'd0);
    chk("arst_clken", 64'(mem_clken), 64'd0);
    chk("arst_write", 64'(mem_write), 64'd0);
    chk("arst_outs", {mem_writedata[47:0], mem_byteenable, 8'(mem_address)}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    trigger = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    trigger = 1'b0;
    sample_valid = 1'b0;
    tick();
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_ww", 64'(words_written), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
